fetch_sequencer: RTL and testbench

- Drives the program counter's update interface: next-address bus plus change-address strobe.
- Reads the PC's current address and fetches the instruction at that address over a request/acknowledge memory port.
- Presents each fetched instruction downstream with a valid/ready handshake.
- Sequences PC+2 advance, taken-branch redirects with squashing of in-flight fetches, and fetch timeout faults.

---
 rtl/fetch_sequencer_if.sv | 37 +++
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bundle of the PC-update, memory-fetch, instruction-delivery and redirect
// signals around the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] inp_pcAddress;
  logic [ADDR_WIDTH-1:0] out_nextInstructionAddress;
  logic                  out_changeAddress;
  logic                  out_memReq;
  logic [ADDR_WIDTH-1:0] out_memAddr;
  logic                  inp_memAck;
  logic [DATA_WIDTH-1:0] inp_memData;
  logic [DATA_WIDTH-1:0] out_instruction;
  logic [ADDR_WIDTH-1:0] out_instrAddress;
  logic                  out_instrValid;
  logic                  inp_instrReady;
  logic                  inp_branchTaken;
  logic [ADDR_WIDTH-1:0] inp_branchTarget;
  logic                  out_fault;

  modport master (
    input  inp_pcAddress, inp_memAck, inp_memData, inp_instrReady,
           inp_branchTaken, inp_branchTarget,
    output out_nextInstructionAddress, out_changeAddress, out_memReq,
           out_memAddr, out_instruction, out_instrAddress, out_instrValid,
           out_fault
  );

  modport slave (
    output inp_pcAddress, inp_memAck, inp_memData, inp_instrReady,
           inp_branchTaken, inp_branchTarget,
    input  out_nextInstructionAddress, out_changeAddress, out_memReq,
           out_memAddr, out_instruction, out_instrAddress, out_instrValid,
           out_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers the PC, fetches over a req/ack port,
// hands instructions downstream, and handles redirects and fetch timeouts.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = 16'h1040,
  parameter int                    ACK_TIMEOUT = 15
) (
  input logic                inp_clk,
  input logic                inp_reset_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_REDIRECT = 3'd1,
    S_FETCH    = 3'd2,
    S_HOLD     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam int                WAIT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  change_q, change_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic                  squash_q, squash_d;
  logic [ADDR_WIDTH-1:0] pending_q, pending_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] target_s;

  assign target_s = {bus.inp_branchTarget[ADDR_WIDTH-1:1], 1'b0};

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d   = state_q;
    change_d  = 1'b0;
    next_d    = next_q;
    instr_d   = instr_q;
    iaddr_d   = iaddr_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    squash_d  = squash_q;
    pending_d = pending_q;
    wait_d    = wait_q;
    case (state_q)
      S_BOOT: begin
        change_d = 1'b1;
        next_d   = RESET_ADDR;
        state_d  = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (bus.inp_branchTaken) begin
          change_d = 1'b1;
          next_d   = target_s;
        end else begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (bus.inp_memAck) begin
          if (squash_q || bus.inp_branchTaken) begin
            // The newest redirect wins over the one parked while waiting.
            change_d = 1'b1;
            next_d   = bus.inp_branchTaken ? target_s : pending_q;
            squash_d = 1'b0;
            state_d  = S_REDIRECT;
          end else begin
            instr_d  = bus.inp_memData;
            iaddr_d  = bus.inp_pcAddress;
            valid_d  = 1'b1;
            change_d = 1'b1;
            next_d   = bus.inp_pcAddress + ADDR_WIDTH'(2);
            state_d  = S_HOLD;
          end
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (bus.inp_branchTaken) begin
            squash_d  = 1'b1;
            pending_d = target_s;
          end else begin
            squash_d  = squash_q;
          end
        end
      end
      S_HOLD: begin
        if (bus.inp_branchTaken) begin
          valid_d  = 1'b0;
          change_d = 1'b1;
          next_d   = target_s;
          state_d  = S_REDIRECT;
        end else if (bus.inp_instrReady) begin
          valid_d = 1'b0;
          wait_d  = '0;
          state_d = S_FETCH;
        end else begin
          valid_d = valid_q;
        end
      end
      S_FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    mem_req_d = (state_d == S_FETCH);
  end

  // State and output registers; reset abandons any outstanding fetch
  always_ff @(posedge inp_clk or negedge inp_reset_n) begin
    if (!inp_reset_n) begin
      state_q   <= S_BOOT;
      change_q  <= 1'b0;
      next_q    <= '0;
      instr_q   <= '0;
      iaddr_q   <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      squash_q  <= 1'b0;
      pending_q <= '0;
      wait_q    <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      change_q  <= change_d;
      next_q    <= next_d;
      instr_q   <= instr_d;
      iaddr_q   <= iaddr_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      squash_q  <= squash_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign bus.out_nextInstructionAddress = next_q;
  assign bus.out_changeAddress          = change_q;
  assign bus.out_memReq                 = mem_req_q;
  assign bus.out_memAddr                = bus.inp_pcAddress;
  assign bus.out_instruction            = instr_q;
  assign bus.out_instrAddress           = iaddr_q;
  assign bus.out_instrValid             = valid_q;
  assign bus.out_fault                  = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table and corner sequences,
// then randomized traffic checked against an instruction-stream model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  // Model of the external program counter.
  logic [15:0] pc_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= 16'h0000;
    else if (bus.out_changeAddress) pc_q <= bus.out_nextInstructionAddress;
  end
  assign bus.inp_pcAddress = pc_q;

  fetch_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_ADDR(16'h1040), .ACK_TIMEOUT(15)
  ) dut (
    .inp_clk(clk),
    .inp_reset_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        ack;
    logic [15:0] data;
    logic        ready;
    logic        chg;
    logic [15:0] nxt;
    logic        req;
    logic [15:0] maddr;
    logic        vld;
    logic [15:0] ia;
    logic [15:0] ins;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [127:0] pack(input logic fault, input logic chg, input logic [15:0] nxt,
                                        input logic req, input logic [15:0] maddr, input logic vld,
                                        input logic [15:0] ia, input logic [15:0] ins);
    return {60'd0, fault, chg, nxt, req, maddr, vld, ia, ins};
  endfunction

  function automatic logic [127:0] obs();
    return pack(bus.out_fault, bus.out_changeAddress, bus.out_nextInstructionAddress,
                bus.out_memReq, bus.out_memAddr, bus.out_instrValid,
                bus.out_instrAddress, bus.out_instruction);
  endfunction

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ack, input logic [15:0] data, input logic ready,
                       input logic br, input logic [15:0] tgt);
    bus.inp_memAck       = ack;
    bus.inp_memData      = data;
    bus.inp_instrReady   = ready;
    bus.inp_branchTaken  = br;
    bus.inp_branchTarget = tgt;
  endtask

  initial begin
    int chg_cnt;
    int req_run;
    int ndel;
    logic [15:0] exp_addr;
    logic dirty;
    logic pv_req, pv_valid, pv_ready, pv_branch, pv_change;
    logic [15:0] pv_ia, pv_ins;
    logic ack, rdy, br;
    logic [15:0] tgt, dat;

    tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1040, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 16'hA001, 1'b1, 1'b0, 16'h1040, 1'b1, 16'h1040, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1042, 1'b0, 16'h1040, 1'b1, 16'h1040, 16'hA001};
    tbl[4] = '{1'b1, 16'hA002, 1'b1, 1'b0, 16'h1042, 1'b1, 16'h1042, 1'b0, 16'h1040, 16'hA001};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1044, 1'b0, 16'h1042, 1'b1, 16'h1042, 16'hA002};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1044, 1'b1, 16'h1044, 1'b0, 16'h1042, 16'hA002};

    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    check("reset_state", obs(), pack(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0));
    rst_n = 1'b1;

    // Boot and two back-to-back fetches.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("boot_vec%0d", i), obs(),
            pack(1'b0, tbl[i].chg, tbl[i].nxt, tbl[i].req, tbl[i].maddr, tbl[i].vld, tbl[i].ia, tbl[i].ins));
      drive(tbl[i].ack, tbl[i].data, tbl[i].ready, 1'b0, 16'h0000);
      step();
    end

    // Backpressure; stray acks outside FETCH must be ignored.
    drive(1'b1, 16'hB044, 1'b0, 1'b0, 16'h0000);
    step();
    chg_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {bus.out_instrValid, bus.out_memReq, bus.out_instrAddress, bus.out_instruction},
            {1'b1, 1'b0, 16'h1044, 16'hB044});
      if (bus.out_changeAddress) chg_cnt++;
      drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
      step();
    end
    check("bp_one_change", chg_cnt, 1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    step();
    check("bp_release", {bus.out_memReq, bus.out_memAddr, bus.out_instrValid}, {1'b1, 16'h1046, 1'b0});

    // Squash: branch while the ack is delayed.
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h2001);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    step();
    step();
    drive(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000);
    step();
    check("squash_redirect", {bus.out_instrValid, bus.out_changeAddress, bus.out_nextInstructionAddress},
          {1'b0, 1'b1, 16'h2000});
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    step();
    check("squash_refetch", {bus.out_memReq, bus.out_memAddr, bus.out_instrValid, bus.out_changeAddress},
          {1'b1, 16'h2000, 1'b0, 1'b0});

    // Ack and branch together, then address wrap.
    drive(1'b1, 16'h1111, 1'b1, 1'b1, 16'hFFFF);
    step();
    check("ack_branch", {bus.out_instrValid, bus.out_changeAddress, bus.out_nextInstructionAddress},
          {1'b0, 1'b1, 16'hFFFE});
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step();
    check("wrap_fetch", {bus.out_memReq, bus.out_memAddr}, {1'b1, 16'hFFFE});
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
    step();
    check("wrap_hold", {bus.out_instrValid, bus.out_instrAddress, bus.out_instruction,
                        bus.out_changeAddress, bus.out_nextInstructionAddress},
          {1'b1, 16'hFFFE, 16'h1234, 1'b1, 16'h0000});
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    step();
    check("wrap_next_fetch", {bus.out_memReq, bus.out_memAddr}, {1'b1, 16'h0000});

    // Timeout: 15 unacknowledged FETCH cycles.
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    repeat (14) step();
    check("timeout_not_yet", {bus.out_memReq, bus.out_fault}, {1'b1, 1'b0});
    step();
    check("timeout_fault", obs(), pack(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h1234));
    drive(1'b1, 16'h5555, 1'b1, 1'b1, 16'h4000);
    step();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step();
    check("fault_sticky", obs(), pack(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h1234));
    rst_n = 1'b0;
    #1;
    check("fault_reset", obs(), pack(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reboot", {bus.out_fault, bus.out_changeAddress, bus.out_nextInstructionAddress},
          {1'b0, 1'b1, 16'h1040});

    // Mid-fetch reset, then a branch in HOLD with ready high.
    step();
    check("reboot_fetch", {bus.out_memReq, bus.out_memAddr}, {1'b1, 16'h1040});
    step();
    rst_n = 1'b0;
    #1;
    check("midfetch_reset", obs(), pack(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000);
    step();
    check("hold_before_branch", {bus.out_instrValid, bus.out_instrAddress, bus.out_instruction},
          {1'b1, 16'h1040, 16'h7777});
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h3000);
    step();
    check("hold_branch", {bus.out_instrValid, bus.out_changeAddress, bus.out_nextInstructionAddress},
          {1'b0, 1'b1, 16'h3000});
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step();
    check("hold_branch_fetch", {bus.out_memReq, bus.out_memAddr}, {1'b1, 16'h3000});

    // Randomized traffic against the instruction-stream model.
    exp_addr = 16'h3000;
    dirty = 1'b0;
    pv_req = 1'b1; pv_valid = 1'b0; pv_ready = 1'b0; pv_branch = 1'b0; pv_change = 1'b0;
    pv_ia = 16'h0; pv_ins = 16'h0;
    req_run = 0;
    ndel = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pv_valid && !pv_ready && !pv_branch && bus.out_instrValid)
        check("rand_hold_stable", {bus.out_instrAddress, bus.out_instruction}, {pv_ia, pv_ins});
      if (pv_change && !pv_branch)
        check("rand_change_pulse", bus.out_changeAddress, 1'b0);
      check("rand_no_fault", bus.out_fault, 1'b0);

      req_run = bus.out_memReq ? req_run + 1 : 0;
      ack = bus.out_memReq && (req_run >= 8 || $urandom_range(0, 2) == 0);
      dat = ack ? memf(bus.out_memAddr) : 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = 16'($urandom);
      drive(ack, dat, rdy, br, tgt);

      if (bus.out_memReq && !pv_req) dirty = 1'b0;
      if (ack && !dirty && !br)
        check("rand_fetch_addr", bus.out_memAddr, exp_addr);
      if (bus.out_instrValid && rdy) begin
        check("rand_deliver", {bus.out_instrAddress, bus.out_instruction}, {exp_addr, memf(exp_addr)});
        exp_addr = exp_addr + 16'd2;
        ndel++;
      end
      if (br) begin
        exp_addr = {tgt[15:1], 1'b0};
        if (bus.out_memReq) dirty = 1'b1;
      end

      pv_req = bus.out_memReq; pv_valid = bus.out_instrValid; pv_ready = rdy;
      pv_branch = br; pv_change = bus.out_changeAddress;
      pv_ia = bus.out_instrAddress; pv_ins = bus.out_instruction;
      step();
    end
    check("rand_delivered_enough", (ndel > 100), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
